// File: rtl/alu_shifter_core_sync_pkg.sv
// Shared types for the ALU input-stage shifter: operand width, byte type and
// shift direction encoding.
package alu_shifter_pkg;

    localparam int ALU_W = 8;

    typedef logic [ALU_W-1:0] alu_byte_t;

    typedef enum logic {
        SHL = 1'b0,
        SHR = 1'b1
    } shift_dir_e;

endpackage : alu_shifter_pkg

// File: rtl/alu_shifter_core_sync_if.sv
// Bus bundle between the ALU bus-input latch (master) and the input-stage
// shifter (slave): operand, shift controls, output enable, result and carry.
interface alu_shifter_core_sync_if;
    import alu_shifter_pkg::*;

    alu_byte_t db;
    logic      shift_enable;
    logic      shift_right;
    logic      shift_in;
    logic      oe;
    logic      cy_out;
    alu_byte_t out;

    // Side that supplies the operand and controls and consumes the result.
    modport master (
        output db,
        output shift_enable,
        output shift_right,
        output shift_in,
        output oe,
        input  cy_out,
        input  out
    );

    // The shifter itself.
    modport slave (
        input  db,
        input  shift_enable,
        input  shift_right,
        input  shift_in,
        input  oe,
        output cy_out,
        output out
    );

endinterface : alu_shifter_core_sync_if

// File: rtl/alu_shifter_core_sync_shift_mux.sv
// Combinational single-bit shift/pass selector. Produces the next register
// value and the bit shifted out (zero when passing the operand through).
module alu_shift_mux
    import alu_shifter_pkg::*;
(
    input  alu_byte_t db,
    input  logic      shift_enable,
    input  logic      shift_right,
    input  logic      shift_in,
    output alu_byte_t nxt,
    output logic      ncy
);

    shift_dir_e dir;

    assign dir = shift_dir_e'(shift_right);

    // Select pass-through, left shift or right shift; carry is the dropped bit.
    always_comb begin
        nxt = db;
        ncy = 1'b0;
        if (shift_enable) begin
            if (dir == SHR) begin
                nxt = {shift_in, db[ALU_W-1:1]};
                ncy = db[0];
            end else begin
                nxt = {db[ALU_W-2:0], shift_in};
                ncy = db[ALU_W-1];
            end
        end
    end

endmodule : alu_shift_mux

// File: rtl/alu_shifter_core_sync.sv
// ALU input-stage shifter: registers a one-bit shifted (or passed-through)
// operand and its carry, then drives the internal ALU bus when enabled.
// Build option ALU_SHIFTER_TRISTATE_EN: when defined, a disabled output
// floats (8'hzz) for a shared tri-state bus; otherwise it drives 8'h00 so
// several sources can be OR-ed together. The carry output is unaffected.
module alu_shifter_core_sync
    import alu_shifter_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    alu_shifter_core_sync_if.slave  bus
);

    alu_byte_t data_q;
    alu_byte_t data_d;
    logic      cy_q;
    logic      cy_d;

    alu_shift_mux u_shift_mux (
        .db           (bus.db),
        .shift_enable (bus.shift_enable),
        .shift_right  (bus.shift_right),
        .shift_in     (bus.shift_in),
        .nxt          (data_d),
        .ncy          (cy_d)
    );

    // Capture the mux result every cycle; reset wins over any shift request.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            cy_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            cy_q   <= cy_d;
        end
    end

    assign bus.cy_out = cy_q;

    // Output-enable driver is combinational so oe takes effect in the same cycle.
    generate
        for (genvar gi = 0; gi < ALU_W; gi++) begin : g_out_drv
`ifdef ALU_SHIFTER_TRISTATE_EN
            assign bus.out[gi] = bus.oe ? data_q[gi] : 1'bz;
`else
            assign bus.out[gi] = bus.oe ? data_q[gi] : 1'b0;
`endif
        end
    endgenerate

endmodule : alu_shifter_core_sync

// File: tb/tb_alu_shifter_core_sync.sv
// Directed bench for alu_shifter_core_sync: reset, pass-through, left/right
// shifts with carry, zero-cycle output enable and reset priority.
`timescale 1ns/1ps
module tb_alu_shifter_core_sync;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_shifter_core_sync_if bus ();

    alu_shifter_core_sync dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value the bus shows while oe is low, depending on build option.
`ifdef ALU_SHIFTER_TRISTATE_EN
    localparam logic [7:0] OFF_VAL = 8'hzz;
`else
    localparam logic [7:0] OFF_VAL = 8'h00;
`endif

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%h", tag, got);
        end
    endtask

    // Apply inputs, clock once, then sample 1 ns after the edge.
    task automatic step(input logic rst, input logic [7:0] d, input logic se,
                        input logic sr, input logic si);
        reset            = rst;
        bus.db           = d;
        bus.shift_enable = se;
        bus.shift_right  = sr;
        bus.shift_in     = si;
        @(posedge clk);
        #1;
    endtask

    // One clocked transaction with its expected bus value and carry.
    task automatic vec(input string tag, input logic [7:0] d, input logic se,
                       input logic sr, input logic si,
                       input logic [7:0] exp_out, input logic exp_cy);
        step(1'b0, d, se, sr, si);
        chk({tag, ".out"}, bus.out, exp_out);
        chk({tag, ".cy"}, {7'd0, bus.cy_out}, {7'd0, exp_cy});
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        bus.oe = 1'b1;

        // Reset with oe high
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        chk("reset.out", bus.out, 8'h00);
        chk("reset.cy", {7'd0, bus.cy_out}, 8'h00);

        // Pass-through and shifts
        vec("pass_a5",    8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
        vec("shl_81",     8'h81, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1);
        vec("shr_81_in1", 8'h81, 1'b1, 1'b1, 1'b1, 8'hC0, 1'b1);
        vec("shr_01",     8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        vec("shl_80_in1", 8'h80, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1);
        vec("shl_7e_in1", 8'h7E, 1'b1, 1'b0, 1'b1, 8'hFD, 1'b0);
        vec("shr_7e",     8'h7E, 1'b1, 1'b1, 1'b0, 8'h3F, 1'b0);
        vec("pass_dc",    8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0);

        // Register holds 3C with carry 1, then toggle oe within the cycle
        vec("shl_9e", 8'h9E, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1);
        bus.oe = 1'b0;
        #1;
        chk("oe0.out", bus.out, OFF_VAL);
        chk("oe0.cy", {7'd0, bus.cy_out}, 8'h01);
        bus.oe = 1'b1;
        #1;
        chk("oe1.out", bus.out, 8'h3C);
        chk("oe1.cy", {7'd0, bus.cy_out}, 8'h01);

        // Reset overrides a shift request, next cycle shifts normally
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("rst_shift.out", bus.out, 8'h00);
        chk("rst_shift.cy", {7'd0, bus.cy_out}, 8'h00);
        vec("after_rst", 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_shifter_core_sync
